led_trail_pwm: RTL and testbench

LED_TRAIL_PWM -- requirements
Module: led_trail_pwm

---
 rtl/led_trail_pwm_pkg.sv | 13 +
 rtl/led_trail_pwm_ch.sv | 59 +++++
 rtl/led_trail_pwm.sv | 67 ++++++
 tb/tb_led_trail_pwm.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_trail_pwm_pkg.sv
// Shared defaults and brightness-range helper for the LED trail PWM block.
package led_trail_pwm_pkg;

    localparam int DEF_N_LED      = 8;
    localparam int DEF_PWM_BITS   = 8;
    localparam int DEF_DECAY_STEP = 32;

    // Full-scale brightness level for a given PWM resolution.
    function automatic int lvl_max(input int pwm_bits);
        return (1 << pwm_bits) - 1;
    endfunction

endpackage

// File: rtl/led_trail_pwm_ch.sv
// One LED channel: afterglow level register with saturating decay and a registered PWM compare.
module led_trail_ch
    import led_trail_pwm_pkg::*;
#(
    parameter int PWM_BITS   = DEF_PWM_BITS,
    parameter int DECAY_STEP = DEF_DECAY_STEP
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                en,
    input  logic                tick,
    input  logic                led_in,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led_out
);

    localparam logic [PWM_BITS-1:0] LVL_MAX = PWM_BITS'(lvl_max(PWM_BITS));

    logic [PWM_BITS-1:0] level_reg;
    logic [PWM_BITS-1:0] level_next;
    logic [PWM_BITS-1:0] level_dec;
    logic [31:0]         level_wide;
    logic                led_out_reg;

    // Decrement is done at 32 bits so a step larger than the level range still floors at 0.
    assign level_wide = 32'(level_reg);

    always_comb begin
        level_dec = '0;
        if (level_wide > 32'(DECAY_STEP)) begin
            level_dec = PWM_BITS'(level_wide - 32'(DECAY_STEP));
        end
    end

    always_comb begin
        level_next = level_reg;
        if (!en) begin
            level_next = '0;
        end else if (led_in) begin
            level_next = LVL_MAX;
        end else if (tick) begin
            level_next = level_dec;
        end
    end

    // Compare uses the pre-update level, giving two cycles from led_in to led_out.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            level_reg   <= '0;
            led_out_reg <= 1'b0;
        end else begin
            level_reg   <= level_next;
            led_out_reg <= en && (pwm_cnt < level_reg);
        end
    end

    assign led_out = led_out_reg;

endmodule

// File: rtl/led_trail_pwm.sv
// LED afterglow dimmer: shared PWM counter and decay prescaler driving N_LED trail channels.
module led_trail_pwm
    import led_trail_pwm_pkg::*;
#(
    parameter int N_LED      = DEF_N_LED,
    parameter int PWM_BITS   = DEF_PWM_BITS,
    parameter int DECAY_STEP = DEF_DECAY_STEP
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N_LED-1:0] led_in,
    input  logic             en,
    input  logic [15:0]      decay_div,
    output logic [N_LED-1:0] led_out
);

    localparam logic [PWM_BITS-1:0] LVL_MAX  = PWM_BITS'(lvl_max(PWM_BITS));
    localparam logic [PWM_BITS-1:0] CNT_LAST = LVL_MAX - PWM_BITS'(1);

    logic [PWM_BITS-1:0] pwm_cnt_reg;
    logic [PWM_BITS-1:0] pwm_cnt_next;
    logic [15:0]         presc_reg;
    logic [15:0]         presc_next;
    logic [15:0]         presc_last;
    logic                tick;

    // A divider of 0 behaves as 1; ">=" makes a lowered divider tick on the very next edge.
    assign presc_last = (decay_div == 16'd0) ? 16'd0 : decay_div - 16'd1;
    assign tick       = en && (presc_reg >= presc_last);

    always_comb begin
        pwm_cnt_next = pwm_cnt_reg + PWM_BITS'(1);
        if (!en || (pwm_cnt_reg >= CNT_LAST)) begin
            pwm_cnt_next = '0;
        end
        presc_next = presc_reg + 16'd1;
        if (!en || tick) begin
            presc_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pwm_cnt_reg <= '0;
            presc_reg   <= '0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_next;
            presc_reg   <= presc_next;
        end
    end

    for (genvar gi = 0; gi < N_LED; gi++) begin : g_ch
        led_trail_ch #(
            .PWM_BITS  (PWM_BITS),
            .DECAY_STEP(DECAY_STEP)
        ) u_ch (
            .clk    (clk),
            .rstn   (rstn),
            .en     (en),
            .tick   (tick),
            .led_in (led_in[gi]),
            .pwm_cnt(pwm_cnt_reg),
            .led_out(led_out[gi])
        );
    end

endmodule

// File: tb/tb_led_trail_pwm.sv
// Scoreboard bench for led_trail_pwm: stimulus queues cycle-stamped expectations, a monitor checks them.
module tb_led_trail_pwm;

    typedef enum logic [1:0] {K_OUT, K_LVL, K_CNT, K_DUTY} kind_t;

    typedef struct {
        int          at;
        kind_t       kind;
        int          ch;
        int          len;
        logic [7:0]  mask;
        int          expv;
        string       name;
    } item_t;

    item_t sb[$];

    logic        clk       = 1'b0;
    logic        rstn      = 1'b0;
    logic        en        = 1'b0;
    logic [7:0]  led_in    = 8'h00;
    logic [15:0] decay_div = 16'd0;
    logic [7:0]  led_out;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    logic [7:0] lvl_probe [8];
    logic [7:0] cnt_probe;

    led_trail_pwm #(
        .N_LED     (8),
        .PWM_BITS  (8),
        .DECAY_STEP(32)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .led_in   (led_in),
        .en       (en),
        .decay_div(decay_div),
        .led_out  (led_out)
    );

    for (genvar gi = 0; gi < 8; gi++) begin : g_probe
        assign lvl_probe[gi] = dut.g_ch[gi].u_ch.level_reg;
    end
    assign cnt_probe = dut.pwm_cnt_reg;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Insert keeping the queue ordered by target cycle.
    task automatic push(input string name, input kind_t kind, input int at, input int ch,
                        input logic [7:0] mask, input int expv, input int len);
        item_t t;
        int    idx;
        t.at = at; t.kind = kind; t.ch = ch; t.len = len;
        t.mask = mask; t.expv = expv; t.name = name;
        idx = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].at > at) begin
                idx = i;
                break;
            end
        end
        sb.insert(idx, t);
    endtask

    task automatic exp_out(input string name, input int at, input logic [7:0] mask, input int v);
        push(name, K_OUT, at, 0, mask, v, 0);
    endtask

    task automatic exp_lvl(input string name, input int at, input int ch, input int v);
        push(name, K_LVL, at, ch, 8'hFF, v, 0);
    endtask

    task automatic exp_cnt(input string name, input int at, input int v);
        push(name, K_CNT, at, 0, 8'hFF, v, 0);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step(1);
    endtask

    // Clears state via en=0, then enables with a one-cycle pulse on LED 0; b is the enable cycle.
    task automatic start_trail(input logic [15:0] div, output int b);
        en        = 1'b0;
        decay_div = div;
        step(1);
        en     = 1'b1;
        led_in = 8'h01;
        b      = cyc;
        step(1);
        led_in = 8'h00;
    endtask

    initial begin : monitor
        item_t t;
        int    got;
        int    acc;
        forever begin
            @(negedge clk);
            while (sb.size() != 0 && sb[0].at <= cyc) begin
                t = sb.pop_front();
                checks++;
                if (t.at < cyc) begin
                    errors++;
                    $display("FAIL %s missed: sampled cyc=%0d required cyc=%0d", t.name, cyc, t.at);
                end else begin
                    got = 0;
                    case (t.kind)
                        K_OUT: got = int'(led_out & t.mask);
                        K_LVL: got = int'(lvl_probe[t.ch]);
                        K_CNT: got = int'(cnt_probe);
                        K_DUTY: begin
                            acc = 0;
                            for (int k = 0; k < t.len; k++) begin
                                if (k != 0) @(negedge clk);
                                acc += int'(led_out[t.ch]);
                            end
                            got = acc;
                        end
                        default: got = -1;
                    endcase
                    if (got != t.expv) begin
                        errors++;
                        $display("FAIL %s cyc=%0d got=%0d required=%0d", t.name, t.at, got, t.expv);
                    end else begin
                        $display("check %s cyc=%0d got=%0d ok", t.name, t.at, got);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int b;
        int c;
        int e;

        // Reset state
        step(2);
        exp_out("reset_out", cyc, 8'hFF, 0);
        exp_lvl("reset_lvl0", cyc, 0, 0);
        exp_cnt("reset_cnt", cyc, 0);

        // All LEDs lit, then asynchronous reset mid-run
        rstn = 1'b1; en = 1'b1; decay_div = 16'hFFFF; led_in = 8'hFF;
        c = cyc;
        exp_out("lat_all_1", c + 1, 8'hFF, 8'h00);
        exp_out("lat_all_2", c + 2, 8'hFF, 8'hFF);
        exp_out("pre_rst", c + 3, 8'hFF, 8'hFF);
        step(4);
        exp_out("rst_async_out", cyc, 8'hFF, 0);
        exp_lvl("rst_async_lvl5", cyc, 5, 0);
        exp_cnt("rst_async_cnt", cyc, 0);
        #1 rstn = 1'b0;
        step(2);
        rstn = 1'b1; led_in = 8'h00;
        c = cyc;
        exp_out("rel_dark_1", c + 1, 8'hFF, 0);
        exp_out("rel_dark_3", c + 3, 8'hFF, 0);
        exp_out("rel_dark_6", c + 6, 8'hFF, 0);
        step_to(c + 7);

        // Decay trail on LED 0, divider 4
        start_trail(16'd4, b);
        exp_out("dec_lat_1", b + 1, 8'h01, 0);
        exp_out("dec_lat_2", b + 2, 8'h01, 1);
        exp_lvl("dec_load", b + 1, 0, 255);
        exp_lvl("dec_pre_tick", b + 3, 0, 255);
        for (int k = 1; k <= 8; k++) begin
            exp_lvl($sformatf("dec_tick%0d", k), b + 4 * k, 0, (255 - 32 * k) > 0 ? 255 - 32 * k : 0);
        end
        exp_lvl("dec_before8", b + 31, 0, 31);
        exp_lvl("dec_floor", b + 40, 0, 0);
        step_to(b + 41);

        // Duty at level 127 over three PWM periods, then divider lowered below the prescaler
        start_trail(16'd4, b);
        exp_lvl("duty_lvl", b + 17, 0, 127);
        exp_lvl("duty_hold", b + 785, 0, 127);
        push("duty_p1", K_DUTY, b + 20, 0, 8'h01, 127, 255);
        push("duty_p2", K_DUTY, b + 275, 0, 8'h01, 127, 255);
        push("duty_p3", K_DUTY, b + 530, 0, 8'h01, 127, 255);
        step_to(b + 16);
        decay_div = 16'hFFFF;
        step_to(b + 786);
        e = cyc;
        decay_div = 16'd4;
        exp_lvl("lower_div_tick", e + 1, 0, 95);
        exp_lvl("lower_div_hold", e + 4, 0, 95);
        exp_lvl("lower_div_next", e + 5, 0, 63);
        step_to(e + 6);

        // Load and tick colliding on LED 3, divider 1
        c = cyc;
        decay_div = 16'd1; led_in = 8'h08;
        exp_out("col_lat_1", c + 1, 8'h08, 0);
        for (int k = 2; k <= 10; k++) begin
            exp_out($sformatf("col_high%0d", k), c + k, 8'h08, 8'h08);
        end
        exp_lvl("col_lvl_1", c + 1, 3, 255);
        exp_lvl("col_lvl_10", c + 10, 3, 255);
        exp_lvl("col_release", c + 11, 3, 223);
        exp_lvl("col_dec_31", c + 17, 3, 31);
        exp_lvl("col_dec_0", c + 18, 3, 0);
        step(10);
        led_in = 8'h00;
        step_to(c + 19);

        // Divider 0 acts as 1 on LED 4
        c = cyc;
        decay_div = 16'd0; led_in = 8'h10;
        exp_lvl("div0_load", c + 1, 4, 255);
        exp_lvl("div0_dec1", c + 2, 4, 223);
        exp_lvl("div0_dec4", c + 5, 4, 127);
        exp_lvl("div0_dec7", c + 8, 4, 31);
        exp_lvl("div0_zero", c + 9, 4, 0);
        exp_lvl("div0_stay", c + 12, 4, 0);
        step(1);
        led_in = 8'h00;
        step_to(c + 13);

        // Enable dropped mid-trail, led_in ignored, then re-enabled
        c = cyc;
        decay_div = 16'hFFFF; led_in = 8'hFF;
        step(1);
        led_in = 8'h00;
        step_to(c + 4);
        exp_out("en_pre", c + 4, 8'hFF, 8'hFF);
        en = 1'b0; led_in = 8'hFF;
        exp_out("en_off_out", c + 5, 8'hFF, 0);
        exp_lvl("en_off_lvl0", c + 5, 0, 0);
        exp_lvl("en_off_lvl7", c + 5, 7, 0);
        exp_cnt("en_off_cnt", c + 5, 0);
        exp_out("en_off_ign", c + 8, 8'hFF, 0);
        exp_lvl("en_off_ign_lvl2", c + 8, 2, 0);
        step_to(c + 9);
        en = 1'b1; led_in = 8'h80;
        exp_cnt("en_cnt_start", c + 9, 0);
        exp_cnt("en_cnt_next", c + 10, 1);
        exp_out("en_on_lat1", c + 10, 8'hFF, 8'h00);
        exp_out("en_on_lat2", c + 11, 8'hFF, 8'h80);
        step_to(c + 14);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 50 && sb.size() != 0; i++) step(1);
        while (sb.size() != 0) begin
            item_t t;
            t = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s never sampled: cyc=%0d required cyc=%0d", t.name, cyc, t.at);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
